// File: rtl/lfsr_checker.sv
// ============================================================================
// Module      : lfsr_checker
// Description : Self-synchronising receive-side checker for the 6-bit XNOR
//               pseudo-random generator; predicts each word and flags errors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_checker #(
   parameter int LOCK_COUNT   = 4,
   parameter int UNLOCK_COUNT = 3,
   parameter int ERR_CNT_W    = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [5:0]           in_data,
   output logic                 locked,
   output logic                 err_pulse,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic                 stuck,
   output logic [5:0]           expected
);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [3:0] c_lock_count   = 4'(LOCK_COUNT);
   localparam logic [3:0] c_unlock_count = 4'(UNLOCK_COUNT);
   localparam logic [5:0] c_lockup_word  = 6'h3F;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [5:0]           r_prev;
   logic [5:0]           w_prev_nxt;
   logic [3:0]           r_match_cnt;
   logic [3:0]           w_match_cnt_nxt;
   logic [3:0]           r_miss_cnt;
   logic [3:0]           w_miss_cnt_nxt;
   logic                 r_locked;
   logic                 r_err_pulse;
   logic                 w_err_pulse_nxt;
   logic [ERR_CNT_W-1:0] r_err_count;
   logic [ERR_CNT_W-1:0] w_err_count_nxt;
   logic                 r_stuck;
   logic                 w_stuck_nxt;
   logic [5:0]           w_pred;
   logic                 w_is_lockup;

   assign w_pred      = {r_prev[4:0], ~(r_prev[5] ^ r_prev[4])};
   assign w_is_lockup = (in_data == c_lockup_word);

   always_comb begin
      w_state_nxt     = r_state;
      w_prev_nxt      = r_prev;
      w_match_cnt_nxt = r_match_cnt;
      w_miss_cnt_nxt  = r_miss_cnt;
      w_err_pulse_nxt = 1'b0;
      w_err_count_nxt = r_err_count;
      w_stuck_nxt     = r_stuck | (in_valid & w_is_lockup);

      if (in_valid) begin
         case (r_state)
            HUNT: begin
               // The lockup word maps to itself, so it can never seed sync.
               if (!w_is_lockup) begin
                  w_prev_nxt      = in_data;
                  w_match_cnt_nxt = 4'd0;
                  w_state_nxt     = VERIFY;
               end
            end
            VERIFY: begin
               w_prev_nxt = in_data;
               if ((in_data == w_pred) && !w_is_lockup) begin
                  w_match_cnt_nxt = r_match_cnt + 4'd1;
                  if ((r_match_cnt + 4'd1) == c_lock_count) begin
                     w_state_nxt = LOCKED;
                  end
               end else begin
                  w_match_cnt_nxt = 4'd0;
                  if (w_is_lockup) begin
                     w_state_nxt = HUNT;
                  end
               end
            end
            LOCKED: begin
               // Flywheel on the prediction so one bad word cannot desync us.
               w_prev_nxt = w_pred;
               if (in_data == w_pred) begin
                  w_miss_cnt_nxt = 4'd0;
               end else begin
                  w_err_pulse_nxt = 1'b1;
                  if (r_err_count != {ERR_CNT_W{1'b1}}) begin
                     w_err_count_nxt = r_err_count + 1'b1;
                  end
                  if ((r_miss_cnt + 4'd1) == c_unlock_count) begin
                     w_state_nxt     = HUNT;
                     w_match_cnt_nxt = 4'd0;
                     w_miss_cnt_nxt  = 4'd0;
                  end else begin
                     w_miss_cnt_nxt = r_miss_cnt + 4'd1;
                  end
               end
            end
            default: begin
               w_state_nxt = HUNT;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= HUNT;
         r_prev      <= 6'h00;
         r_match_cnt <= 4'd0;
         r_miss_cnt  <= 4'd0;
         r_locked    <= 1'b0;
         r_err_pulse <= 1'b0;
         r_err_count <= '0;
         r_stuck     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_prev      <= w_prev_nxt;
         r_match_cnt <= w_match_cnt_nxt;
         r_miss_cnt  <= w_miss_cnt_nxt;
         r_locked    <= (w_state_nxt == LOCKED);
         r_err_pulse <= w_err_pulse_nxt;
         r_err_count <= w_err_count_nxt;
         r_stuck     <= w_stuck_nxt;
      end
   end

   assign locked    = r_locked;
   assign err_pulse = r_err_pulse;
   assign err_count = r_err_count;
   assign stuck     = r_stuck;
   assign expected  = w_pred;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_checker.sv
// ============================================================================
// Module      : tb_lfsr_checker
// Description : Directed self-checking bench for lfsr_checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lfsr_checker;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [5:0] in_data;

   logic       locked,   locked_s;
   logic       err_pulse, err_pulse_s;
   logic [7:0] err_count;
   logic [1:0] err_count_s;
   logic       stuck,    stuck_s;
   logic [5:0] expected, expected_s;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   lfsr_checker #(.LOCK_COUNT(4), .UNLOCK_COUNT(3), .ERR_CNT_W(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
      .stuck(stuck), .expected(expected)
   );

   // Narrow error counter instance for saturation behaviour.
   lfsr_checker #(.LOCK_COUNT(4), .UNLOCK_COUNT(3), .ERR_CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .locked(locked_s), .err_pulse(err_pulse_s), .err_count(err_count_s),
      .stuck(stuck_s), .expected(expected_s)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_beat(input logic [5:0] d);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic lock_seq(input string tag);
      drive_beat(6'h00);
      drive_beat(6'h01);
      drive_beat(6'h03);
      drive_beat(6'h07);
      check_eq({tag, "_prelock"}, locked, 1'b0);
      drive_beat(6'h0F);
      check_eq({tag, "_locked"}, locked, 1'b1);
      check_eq({tag, "_expected"}, expected, 6'h1F);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 6'h00;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_locked",   locked,    1'b0);
      check_eq("rst_pulse",    err_pulse, 1'b0);
      check_eq("rst_errcnt",   err_count, 8'd0);
      check_eq("rst_stuck",    stuck,     1'b0);
      check_eq("rst_expected", expected,  6'h01);
      @(negedge clk);
      reset = 1'b0;

      // Basic lock followed by a single corrupted word
      lock_seq("lock");
      check_eq("lock_errcnt", err_count, 8'd0);
      drive_beat(6'h1F);
      check_eq("fly_pulse0", err_pulse, 1'b0);
      check_eq("fly_exp0",   expected,  6'h3E);
      drive_beat(6'h00);
      check_eq("fly_pulse1", err_pulse, 1'b1);
      check_eq("fly_err1",   err_count, 8'd1);
      check_eq("fly_lock1",  locked,    1'b1);
      drive_beat(6'h3D);
      check_eq("fly_pulse2", err_pulse, 1'b0);
      check_eq("fly_lock2",  locked,    1'b1);
      drive_beat(6'h3B);
      check_eq("fly_pulse3", err_pulse, 1'b0);
      check_eq("fly_err3",   err_count, 8'd1);
      check_eq("fly_exp3",   expected,  6'h37);

      // Three consecutive misses drop lock, then relock
      do_reset();
      lock_seq("unl");
      drive_beat(6'h00);
      check_eq("unl_pulse1", err_pulse, 1'b1);
      check_eq("unl_lock1",  locked,    1'b1);
      drive_beat(6'h00);
      check_eq("unl_pulse2", err_pulse, 1'b1);
      check_eq("unl_err2",   err_count, 8'd2);
      drive_beat(6'h00);
      check_eq("unl_pulse3", err_pulse, 1'b1);
      check_eq("unl_err3",   err_count, 8'd3);
      check_eq("unl_lock3",  locked,    1'b0);
      check_eq("unl_exp3",   expected,  6'h3B);
      drive_beat(6'h0F);
      check_eq("unl_pulse4", err_pulse, 1'b0);
      drive_beat(6'h1F);
      drive_beat(6'h3E);
      drive_beat(6'h3D);
      check_eq("rel_prelock", locked, 1'b0);
      drive_beat(6'h3B);
      check_eq("rel_locked",  locked,    1'b1);
      check_eq("rel_errcnt",  err_count, 8'd3);

      // Gaps in the valid stream do not change lock timing
      do_reset();
      drive_beat(6'h00);
      drive_beat(6'h01);
      for (int i = 0; i < 5; i++) drive_idle();
      check_eq("gap_hold_exp", expected, 6'h03);
      check_eq("gap_hold_lck", locked,   1'b0);
      drive_beat(6'h03);
      drive_beat(6'h07);
      check_eq("gap_prelock", locked, 1'b0);
      drive_beat(6'h0F);
      check_eq("gap_locked",  locked, 1'b1);

      // Mismatch in VERIFY re-seeds the chain
      do_reset();
      drive_beat(6'h00);
      drive_beat(6'h01);
      drive_beat(6'h05);
      check_eq("rsd_exp",    expected,  6'h0B);
      check_eq("rsd_pulse",  err_pulse, 1'b0);
      drive_beat(6'h0B);
      drive_beat(6'h17);
      drive_beat(6'h2E);
      check_eq("rsd_prelock", locked, 1'b0);
      drive_beat(6'h1C);
      check_eq("rsd_locked",  locked,    1'b1);
      check_eq("rsd_errcnt",  err_count, 8'd0);

      // Lockup word in HUNT, then saturation on the narrow counter
      do_reset();
      drive_beat(6'h3F);
      check_eq("stk_stuck",   stuck,    1'b1);
      check_eq("stk_stuck_s", stuck_s,  1'b1);
      check_eq("stk_exp",     expected, 6'h01);
      check_eq("stk_lock",    locked,   1'b0);
      lock_seq("sat");
      drive_beat(6'h00);
      check_eq("sat_e1", err_count_s, 2'd1);
      drive_beat(6'h3E);
      drive_beat(6'h00);
      check_eq("sat_e2", err_count_s, 2'd2);
      drive_beat(6'h3B);
      drive_beat(6'h00);
      check_eq("sat_e3", err_count_s, 2'd3);
      drive_beat(6'h2F);
      drive_beat(6'h00);
      check_eq("sat_e4",      err_count_s, 2'd3);
      check_eq("sat_pulse4",  err_pulse_s, 1'b1);
      drive_beat(6'h3C);
      check_eq("sat_pulse4b", err_pulse_s, 1'b0);
      drive_beat(6'h00);
      check_eq("sat_e5",      err_count_s, 2'd3);
      check_eq("sat_pulse5",  err_pulse_s, 1'b1);
      check_eq("sat_wide",    err_count,   8'd5);
      check_eq("sat_lock",    locked_s,    1'b1);
      check_eq("sat_stuck",   stuck,       1'b1);
      drive_idle();
      check_eq("sat_idle_pulse", err_pulse, 1'b0);

      // Reset while locked with errors and stuck set, with a beat presented
      do_reset();
      drive_beat(6'h3F);
      lock_seq("mid");
      drive_beat(6'h00);
      drive_beat(6'h00);
      check_eq("mid_err2",  err_count, 8'd2);
      check_eq("mid_lock",  locked,    1'b1);
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b1;
      in_data  = 6'h00;
      @(posedge clk);
      #1;
      check_eq("mid_rst_locked", locked,    1'b0);
      check_eq("mid_rst_pulse",  err_pulse, 1'b0);
      check_eq("mid_rst_errcnt", err_count, 8'd0);
      check_eq("mid_rst_stuck",  stuck,     1'b0);
      check_eq("mid_rst_exp",    expected,  6'h01);
      @(negedge clk);
      reset    = 1'b0;
      in_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
